// File: rtl/cdb_arbiter.sv
// Writeback arbiter: per-producer holding registers, rotating-priority grants onto registered CDBs.
// Optional same-cycle bypass of empty holding registers when CDB_BYPASS_EN is defined.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_BUS   = 2,
    parameter int PAYLOAD_W = 56
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]       req_payload,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_BUS*(PAYLOAD_W+1)-1:0]   bus_out,
    output logic [NUM_REQ-1:0]                 grant_vec,
    output logic [15:0]                        conflict_cnt
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SLOT_W = PAYLOAD_W + 1;

    logic [NUM_REQ-1:0]          hold_valid;
    logic [PAYLOAD_W-1:0]        hold_payload [NUM_REQ];
    logic [PTR_W-1:0]            rr_ptr;
    logic [PTR_W-1:0]            rr_next;
    logic [NUM_REQ-1:0]          cand;
    logic [NUM_REQ-1:0]          load;
    logic [PAYLOAD_W-1:0]        cand_payload [NUM_REQ];
    logic [SLOT_W-1:0]           slot_next [NUM_BUS];
    logic [NUM_BUS*SLOT_W-1:0]   bus_next;
    logic                        conflict;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CDB_BYPASS_EN
            cand[i] = hold_valid[i] | req_valid[i];
            cand_payload[i] = hold_valid[i] ? hold_payload[i]
                                            : req_payload[i*PAYLOAD_W +: PAYLOAD_W];
`else
            cand[i] = hold_valid[i];
            cand_payload[i] = hold_payload[i];
`endif
        end
    end

    always_comb begin
        int n_grant;
        int n_cand;
        logic [PTR_W-1:0] idx;
        n_grant   = 0;
        n_cand    = 0;
        idx       = '0;
        grant_vec = '0;
        rr_next   = rr_ptr;
        for (int k = 0; k < NUM_BUS; k++) begin
            slot_next[k] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = PTR_W'((int'(rr_ptr) + j) % NUM_REQ);
            if (cand[idx]) begin
                n_cand++;
                if (n_grant < NUM_BUS) begin
                    grant_vec[idx] = 1'b1;
                    for (int k = 0; k < NUM_BUS; k++) begin
                        if (n_grant == k) begin
                            slot_next[k] = {1'b1, cand_payload[idx]};
                        end
                    end
                    rr_next = PTR_W'((int'(idx) + 1) % NUM_REQ);
                    n_grant++;
                end
            end
        end
        conflict = (n_cand > NUM_BUS);
        bus_next = '0;
        for (int k = 0; k < NUM_BUS; k++) begin
            bus_next[k*SLOT_W +: SLOT_W] = slot_next[k];
        end
    end

    assign req_ready = ~hold_valid | grant_vec;

`ifdef CDB_BYPASS_EN
    // A bypass-granted offer is consumed straight onto the bus, not stored.
    assign load = req_valid & req_ready & ~(grant_vec & ~hold_valid);
`else
    assign load = req_valid & req_ready;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid   <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
            bus_out      <= '0;
        end else begin
            bus_out <= bus_next;
            rr_ptr  <= rr_next;
            if (conflict && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (load[i]) begin
                    hold_valid[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (load[i]) begin
                hold_payload[i] <= req_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates result writeback from up to four producers onto the two shared common data buses, which feed RS operand forwarding, the ROB and the ARF ready bits. The producers are three ALU result paths plus the load/store unit. Each producer has a one-entry holding register with a valid/ready handshake. A rotating-priority scheduler grants up to two held results per cycle and drives them onto registered bus outputs in the `{valid, pc, result, rd, rob}` bus format. It replaces direct result-buffer-to-bus wiring now that producers outnumber buses.

## Interface
- `NUM_REQ`, 4: number of producers; legal range 2..8.
- `NUM_BUS`, 2: number of output buses; legal range 1..`NUM_REQ`.
- `PAYLOAD_W`, 56: producer payload width, `{pc[11:0], res[31:0], rd[5:0], rob[5:0]}`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `req_valid` input `NUM_REQ`: bit i means producer i offers a payload this cycle.
- `req_payload` input `NUM_REQ*PAYLOAD_W`: producer i's payload occupies slice `[i*PAYLOAD_W +: PAYLOAD_W]`.
- `req_ready` output `NUM_REQ`: bit i means the holding register of producer i accepts this cycle.
- `bus_out` output `NUM_BUS*(PAYLOAD_W+1)`: slot k is `{valid, payload}` at slice `[k*(PAYLOAD_W+1) +: PAYLOAD_W+1]`; registered.
- `grant_vec` output `NUM_REQ`: producers granted onto the buses this cycle; combinational.
- `conflict_cnt` output 16: saturating count of cycles in which there were more candidates than `NUM_BUS`.

## Operation
- **Holding registers.** Producer i has `hold_valid[i]` and `hold_payload[i]`.
- **Ready.** `req_ready[i] = ~hold_valid[i] | grant_vec[i]`. This allows back-to-back accept with no bubble.
- **Accept.** A transfer happens when `req_valid[i] & req_ready[i]`. At the edge, the hold register loads the payload and `hold_valid[i]` goes to 1.
- **Candidates.** A candidate is any entry with `hold_valid[i]=1`.
- **Scan.** Candidates are scanned starting at `rr_ptr` and wrapping modulo `NUM_REQ`. The first `NUM_BUS` candidates found are granted.
- **Bus slot order.** The 1st grant goes to slot 0, the 2nd to slot 1, and so on. Slots left unfilled drive valid=0 and payload=0.
- **Grant effects.** At the edge, each granted entry is copied to its bus slot with valid=1. Its `hold_valid` clears unless a new accept to the same index occurs in the same cycle; in that case it reloads and stays 1.
- **Pointer update.** `rr_ptr` moves to (index of last grant + 1) mod `NUM_REQ`. With no grant it is unchanged.
- **Conflict counter.** `conflict_cnt` increments when the candidate count exceeds `NUM_BUS`. It holds at 16'hFFFF.
- **Ordering.** Ordering within one producer is preserved, because each producer has a single entry. No payload is ever dropped or duplicated.
- **Producer rule.** A producer must hold `req_valid` and `req_payload` stable until accepted.

## Timing
- **Reset.** While `rst`=0, asynchronously:
  - all `hold_valid`=0;
  - `bus_out` all zero;
  - `rr_ptr`=0;
  - `conflict_cnt`=0;
  - `req_ready` = all ones, because it follows from the empty holds;
  - `grant_vec`=0.

  Reset asserted mid-operation discards all held payloads. The first edge after `rst` rises behaves as cycle 0.
- **Latency.** With no bypass, a payload accepted at edge N is a candidate in cycle N+1. It appears on the bus after edge N+1, so the minimum latency is 2 edges.
- **Bus hold time.** Bus outputs are valid for exactly one cycle per grant. They are not held.
- **Throughput.** Sustained throughput is `NUM_BUS` results per cycle.
- **Worst-case wait.** Under continuous contention, a held entry waits at most ceil((`NUM_REQ`-1)/`NUM_BUS`) cycles.

## Configuration
- `CDB_BYPASS_EN` defined: a producer with `hold_valid[i]=0` and `req_valid[i]=1` is also a candidate in the same cycle.
  - If granted, its payload goes straight to the bus at that edge and the hold register stays empty. Latency is then 1 edge.
  - If not granted, it loads the hold register as normal.
  - Held entries and bypass entries share the same rotation order.
- `CDB_BYPASS_EN` undefined: only held entries are candidates, with the fixed 2-edge minimum latency.

## Test plan
- **Reset.** Drive `rst`=0 asynchronously mid-burst with holds full. Required:
  - immediately, `bus_out`=0, `req_ready`=4'b1111 and `conflict_cnt`=0;
  - after release, no stale payload appears.
- **Single producer, no bypass.** Producer 2 offers {pc=12'h010, res=32'hDEADBEEF, rd=6'd5, rob=6'd3} for one cycle. Required:
  - slot 0 carries it with valid=1 exactly 2 edges after the offer;
  - slot 1 valid=0;
  - `rr_ptr`=3 afterward.
- **Full contention.** All four producers are valid with `rr_ptr`=0. Required:
  - first grant cycle: slot0=req0, slot1=req1, `conflict_cnt`=1;
  - next cycle: slot0=req2, slot1=req3.
- **Fairness.** All four producers re-offer continuously for 8 grant cycles. Required:
  - each producer is granted exactly 4 times;
  - the grant pattern alternates {0,1},{2,3};
  - `conflict_cnt`=8.
- **Backpressure.** Producer 3 holds an entry but loses arbitration, then offers a new payload. Required:
  - `req_ready[3]`=0 until its grant;
  - the new payload is accepted on the grant cycle;
  - both payloads appear in order with none lost.
- **`CDB_BYPASS_EN` defined.** A lone producer 1 offer is used. Required:
  - it appears on slot 0 after 1 edge;
  - the holding register stays empty.
